data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Bus-side responder (slave) for the core's data-memory interface: DAD, DDT, MREQ, WRITE, SIZE and ACKD_n.
- Decodes requests and performs byte, half or word reads and writes on an internal word-organised RAM.
- Inserts a programmable number of wait states, then acknowledges with ACKD_n low.
- Sits opposite the CPU top in the SoC/testbench, replacing the behavioural memory model.

Parameters:
- ADDR_BITS, 14: byte-address bits decoded. RAM depth is 2**(ADDR_BITS-2) words.
- BASE_ADDR, 32'h0000_0000: address of RAM word 0. Must be 2**ADDR_BITS-aligned.
- WAIT_CYCLES, 1: wait states between request acceptance and acknowledge. Legal range 0..15.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- DAD, input, 32: byte address from the initiator.
- DDT, inout, 32: data bus. Driven by this block only during a read acknowledge cycle, otherwise high-Z.
- MREQ, input, 1: 1 = access requested.
- WRITE, input, 1: 1 = write, 0 = read. Valid while MREQ=1.
- SIZE, input, 2: 00 byte, 01 half, 10 word. 11 is illegal.
- ACKD_n, output, 1: 0 = access complete this cycle.
- err, output, 1: sticky access-error flag.
- err_addr, output, 32: DAD of the first erroring access.

Behaviour:
- Reset: asynchronous, active-high.
  - State = IDLE, ACKD_n=1, DDT=Z, err=0, err_addr=0, wait counter=0.
  - RAM contents are not cleared.
  - Reset asserted mid-access: abort immediately, no write commits.
- Request hold rule: the initiator holds MREQ, DAD, WRITE, SIZE and the write data stable until it samples ACKD_n=0.
- Capture: in IDLE, with MREQ=1 at an edge, latch DAD, WRITE, SIZE and DDT (write data) into request registers.
- FSM states: IDLE, WAIT, ACK.
  - IDLE -> WAIT when MREQ=1 and WAIT_CYCLES>0. Counter loads WAIT_CYCLES-1.
  - IDLE -> ACK when MREQ=1 and WAIT_CYCLES=0.
  - WAIT: counter decrements each cycle; at 0 -> ACK.
  - WAIT with MREQ=0 sampled: abort -> IDLE, no write, no ack.
  - ACK: ACKD_n=0 for exactly one cycle, then -> IDLE unconditionally. ACKD_n is a registered output.
- Turnaround: one IDLE cycle with ACKD_n=1 always separates accesses. MREQ still high in that IDLE cycle is taken as a new request.
- Latency (request edge to ACKD_n=0): WAIT_CYCLES+1 cycles.
- Error check, applied at capture:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - SIZE=11.
  - Address outside BASE_ADDR..BASE_ADDR+2**ADDR_BITS-1.
  - An erroring access is still acknowledged normally; a write is suppressed, a read returns 32'h0.
  - err sets on the first error and holds until reset. err_addr records only the first error.
- Writes:
  - Write data is right-aligned on DDT (byte in [7:0], half in [15:0]).
  - The block shifts it to lane addr[1:0]*8 and applies byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - The RAM updates on the edge entering ACK, so a following read sees the new data.
- Reads:
  - RAM word is read at the edge entering ACK.
  - The selected lane is shifted down to bit 0 and zero-extended; the core performs sign extension.
  - DDT is driven only while state=ACK and the captured WRITE=0; high-Z in every other state.
- Endianness: little-endian. Byte at addr[1:0]=0 is bits [7:0].

Decomposition:
- Shared include mem_bus_defs.v, common with the CPU's mem stage:
  - SIZE encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - FSM state localparams.
  - Error-cause constants.
- One sub-module dmem_lane_align (combinational), producing:
  - the write byte-enable mask;
  - the shifted write data;
  - the extracted, zero-extended read data from addr[1:0] and size.
- RAM array plus FSM stay in data_mem_responder.

Test Plan:
- Word write/read, WAIT_CYCLES=1:
  - Stimulus: write 32'hDEADBEEF @0x10, then read @0x10.
  - Required: each access gives ACKD_n=0 exactly 2 cycles after MREQ sampled; DDT=32'hDEADBEEF in the read ACK cycle; DDT=Z elsewhere.
- Byte/half lanes:
  - Stimulus: write word 0x11223344 @0x20; write byte 0xAA @0x21; write half 0xBBCC @0x22; read word @0x20.
  - Required: read returns 0xBBCCAA44. Byte read @0x23 returns 0x000000BB.
- Misaligned and out-of-range:
  - Stimulus: half write 0xFFFF @0x31; then read word @(BASE_ADDR+2**ADDR_BITS).
  - Required: both acknowledged; RAM @0x30 unchanged; the read returns 0; err=1 and err_addr=0x31 after the first error.
- Abort:
  - Stimulus: WAIT_CYCLES=3; word write 0x12345678 @0x40 with MREQ dropped after 1 wait cycle.
  - Required: no ACKD_n=0 pulse; later read @0x40 returns the old value.
- Reset mid-access:
  - Stimulus: reset asserted during a read's WAIT state.
  - Required: ACKD_n=1 and DDT=Z the same cycle, asynchronously; err clears; RAM data intact on a subsequent read.
- Zero-wait back-to-back:
  - Stimulus: WAIT_CYCLES=0, MREQ held high across two reads.
  - Required: ACKD_n pattern 0,1,0 on consecutive cycles starting 1 cycle after the first request.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_responder_pkg
// Definitions shared between the data-memory responder and the core's memory
// stage: SIZE encodings, responder FSM states, access-error causes and a
// helper that classifies a request as legal or erroring.
// ---------------------------------------------------------------------------
package data_mem_responder_pkg;

  // Access size encodings carried on SIZE
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Access-error causes
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_SIZE     = 2'd2,
    ERR_RANGE    = 2'd3
  } err_cause_e;

  // Classify a request; an illegal size takes precedence over alignment,
  // and alignment over the address-range check.
  function automatic err_cause_e classify(input logic [1:0] size,
                                          input logic [1:0] addr_lo,
                                          input logic       in_range);
    err_cause_e cause;
    cause = ERR_NONE;
    if (size == SIZE_ILL) begin
      cause = ERR_SIZE;
    end else if ((size == SIZE_HALF) && addr_lo[0]) begin
      cause = ERR_MISALIGN;
    end else if ((size == SIZE_WORD) && (addr_lo != 2'b00)) begin
      cause = ERR_MISALIGN;
    end else if (!in_range) begin
      cause = ERR_RANGE;
    end else begin
      cause = ERR_NONE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane steering for little-endian sub-word accesses.
// Ports:
//   i_addr_lo [1:0]  : byte offset within the word
//   i_size    [1:0]  : access size (byte/half/word)
//   i_wdata   [31:0] : right-aligned write data from the bus
//   i_rword   [31:0] : full RAM word being read
//   o_be      [3:0]  : write byte enables
//   o_wdata   [31:0] : write data shifted into its byte lane(s)
//   o_rdata   [31:0] : selected read lane shifted to bit 0, zero-extended
// ---------------------------------------------------------------------------
module dmem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [4:0] w_shift;

  // Lane shift amount in bits
  always_comb begin
    w_shift = {i_addr_lo, 3'b000};
  end

  // Byte enables, write lane placement and read lane extraction
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0000_0000;
    o_rdata = 32'h0000_0000;
    case (i_size)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = (i_wdata & 32'h0000_00FF) << w_shift;
        o_rdata = (i_rword >> w_shift) & 32'h0000_00FF;
      end
      SIZE_HALF: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = (i_wdata & 32'h0000_FFFF) << w_shift;
        o_rdata = (i_rword >> w_shift) & 32'h0000_FFFF;
      end
      SIZE_WORD: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
        o_rdata = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Bus-side responder for the core's data-memory interface. Accepts a request
// in IDLE, waits WAIT_CYCLES cycles, then pulses ACKD_n low for one cycle.
// Reads drive DDT only during that acknowledge cycle. Erroring accesses are
// acknowledged normally but never write and read back zero; the first error
// address is kept in err_addr and err stays set until reset.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset
//   DAD      : byte address
//   DDT      : bidirectional data bus
//   MREQ     : access request
//   WRITE    : 1 = write, 0 = read
//   SIZE     : 00 byte, 01 half, 10 word
//   ACKD_n   : registered acknowledge, active low
//   err      : sticky access-error flag
//   err_addr : address of the first erroring access
// ---------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          ADDR_BITS   = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  output logic        ACKD_n,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int         DEPTH     = 2 ** (ADDR_BITS - 2);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_ackd_n;

  logic [31:0] r_addr;
  logic        r_write;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  err_cause_e  r_cause;

  logic        r_err;
  logic [31:0] r_err_addr;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  logic        w_idle;
  logic        w_capture;
  logic [31:0] w_req_addr;
  logic        w_req_write;
  logic [1:0]  w_req_size;
  logic [31:0] w_req_wdata;
  logic        w_in_range;
  err_cause_e  w_new_cause;
  err_cause_e  w_req_cause;
  logic        w_enter_ack;
  logic        w_mem_we;
  logic        w_ddt_oe;
  logic [ADDR_BITS-3:0] w_idx;
  logic [31:0] w_rword;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_rdata_ext;

  // Current request view: live bus in IDLE (covers the zero-wait case where
  // the RAM is accessed on the capture edge itself), captured copy otherwise.
  always_comb begin
    w_idle      = (r_state == ST_IDLE);
    w_capture   = w_idle && MREQ;
    w_req_addr  = w_idle ? DAD   : r_addr;
    w_req_write = w_idle ? WRITE : r_write;
    w_req_size  = w_idle ? SIZE  : r_size;
    w_req_wdata = w_idle ? DDT   : r_wdata;
    w_in_range  = (w_req_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    w_new_cause = classify(w_req_size, w_req_addr[1:0], w_in_range);
    w_req_cause = w_idle ? w_new_cause : r_cause;
    w_idx       = w_req_addr[ADDR_BITS-1:2];
    w_rword     = r_mem[w_idx];
  end

  dmem_lane_align u_lane_align (
    .i_addr_lo (w_req_addr[1:0]),
    .i_size    (w_req_size),
    .i_wdata   (w_req_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_sh),
    .o_rdata   (w_rdata_ext)
  );

  // FSM next-state and wait-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (MREQ) begin
          w_state_nxt = ZERO_WAIT ? ST_ACK : ST_WAIT;
          w_cnt_nxt   = WAIT_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
      ST_WAIT: begin
        // Initiator withdrawing the request aborts the access
        if (!MREQ) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = ST_ACK;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // FSM output decode: RAM commit strobe and bus drive enable
  always_comb begin
    w_enter_ack = (w_state_nxt == ST_ACK) && (r_state != ST_ACK);
    w_mem_we    = w_enter_ack && w_req_write && (w_req_cause == ERR_NONE) && !reset;
    w_ddt_oe    = (r_state == ST_ACK) && !r_write;
  end

  // FSM state, wait counter and registered acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_ackd_n <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ackd_n <= (w_state_nxt != ST_ACK);
    end
  end

  // Request capture, sticky error recording and read-data register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= 32'h0000_0000;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_wdata    <= 32'h0000_0000;
      r_cause    <= ERR_NONE;
      r_err      <= 1'b0;
      r_err_addr <= 32'h0000_0000;
      r_rdata    <= 32'h0000_0000;
    end else begin
      if (w_capture) begin
        r_addr  <= DAD;
        r_write <= WRITE;
        r_size  <= SIZE;
        r_wdata <= DDT;
        r_cause <= w_new_cause;
        if ((w_new_cause != ERR_NONE) && !r_err) begin
          r_err      <= 1'b1;
          r_err_addr <= DAD;
        end
      end
      if (w_enter_ack) begin
        r_rdata <= (!w_req_write && (w_req_cause == ERR_NONE)) ? w_rdata_ext : 32'h0000_0000;
      end
    end
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_mem_we && w_be[b]) begin
        r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  assign DDT      = w_ddt_oe ? r_rdata : 32'hzzzz_zzzz;
  assign ACKD_n   = r_ackd_n;
  assign err      = r_err;
  assign err_addr = r_err_addr;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Three responders with WAIT_CYCLES = 1, 3 and 0. The bench owns DDT with a
// marker value whenever the responder must not drive it, so any stray drive
// shows up as a corrupted marker. Expected read data is queued when a read is
// issued and popped in the acknowledge cycle.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam logic [1:0]  SZ_B   = 2'b00;
  localparam logic [1:0]  SZ_H   = 2'b01;
  localparam logic [1:0]  SZ_W   = 2'b10;
  localparam logic [1:0]  SZ_X   = 2'b11;
  localparam logic [31:0] MARKER = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dad     [3];
  logic        mreq    [3];
  logic        wr      [3];
  logic [1:0]  sz      [3];
  logic        drv_en  [3];
  logic [31:0] drv_val [3];

  wire  [31:0] ddt0, ddt1, ddt2;
  wire         ack0, ack1, ack2;
  wire         err0, err1, err2;
  wire  [31:0] ea0, ea1, ea2;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign ddt0 = drv_en[0] ? drv_val[0] : 32'hzzzz_zzzz;
  assign ddt1 = drv_en[1] ? drv_val[1] : 32'hzzzz_zzzz;
  assign ddt2 = drv_en[2] ? drv_val[2] : 32'hzzzz_zzzz;

  data_mem_responder #(.ADDR_BITS(14), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .DAD(dad[0]), .DDT(ddt0), .MREQ(mreq[0]), .WRITE(wr[0]),
    .SIZE(sz[0]), .ACKD_n(ack0), .err(err0), .err_addr(ea0));
  data_mem_responder #(.ADDR_BITS(14), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .DAD(dad[1]), .DDT(ddt1), .MREQ(mreq[1]), .WRITE(wr[1]),
    .SIZE(sz[1]), .ACKD_n(ack1), .err(err1), .err_addr(ea1));
  data_mem_responder #(.ADDR_BITS(14), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .DAD(dad[2]), .DDT(ddt2), .MREQ(mreq[2]), .WRITE(wr[2]),
    .SIZE(sz[2]), .ACKD_n(ack2), .err(err2), .err_addr(ea2));

  function automatic logic [31:0] ddt_of(input int k);
    case (k)
      0:       return ddt0;
      1:       return ddt1;
      default: return ddt2;
    endcase
  endfunction

  function automatic logic ack_of(input int k);
    case (k)
      0:       return ack0;
      1:       return ack1;
      default: return ack2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access starting just after a rising edge; returns just after
  // the rising edge that follows the turnaround IDLE cycle.
  task automatic access(input int k, input logic w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input int lat,
                        input string tag);
    int          cyc;
    bit          got;
    logic [31:0] want;
    dad[k]     = a;
    wr[k]      = w;
    sz[k]      = s;
    mreq[k]    = 1'b1;
    drv_en[k]  = 1'b1;
    drv_val[k] = w ? d : MARKER;
    if (!w) exp_q.push_back(exp_rd);
    cyc = 0;
    got = 1'b0;
    while (!got && (cyc < 20)) begin
      @(posedge clk); #1;
      cyc++;
      if (!w && (cyc == lat)) drv_en[k] = 1'b0;
      @(negedge clk);
      if (ack_of(k) == 1'b0) got = 1'b1;
      else if (drv_en[k]) chk({tag, "_ddt_idle"}, ddt_of(k), drv_val[k]);
    end
    chk({tag, "_acked"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    if (w) begin
      if (got) chk({tag, "_ddt_wack"}, ddt_of(k), d);
    end else if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      if (got) chk({tag, "_rdata"}, ddt_of(k), want);
    end
    @(posedge clk); #1;
    mreq[k]    = 1'b0;
    drv_en[k]  = 1'b1;
    drv_val[k] = MARKER;
    @(negedge clk);
    chk({tag, "_turnaround"}, 32'(ack_of(k)), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pulses;
    logic [31:0] want;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dad[i]     = 32'h0000_0000;
      mreq[i]    = 1'b0;
      wr[i]      = 1'b0;
      sz[i]      = SZ_W;
      drv_en[i]  = 1'b1;
      drv_val[i] = MARKER;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ackd_n", 32'(ack0), 32'd1);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_err_addr", ea0, 32'h0000_0000);
    chk("rst_ddt", ddt0, MARKER);
    @(posedge clk); #1;

    // Word write then read, one wait state
    access(0, 1'b1, SZ_W, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 2, "w_word10");
    access(0, 1'b0, SZ_W, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2, "r_word10");

    // Sub-word lane merging
    access(0, 1'b1, SZ_W, 32'h0000_0020, 32'h1122_3344, 32'h0, 2, "w_word20");
    access(0, 1'b1, SZ_B, 32'h0000_0021, 32'h0000_00AA, 32'h0, 2, "w_byte21");
    access(0, 1'b1, SZ_H, 32'h0000_0022, 32'h0000_BBCC, 32'h0, 2, "w_half22");
    access(0, 1'b0, SZ_W, 32'h0000_0020, 32'h0, 32'hBBCC_AA44, 2, "r_word20");
    access(0, 1'b0, SZ_B, 32'h0000_0023, 32'h0, 32'h0000_00BB, 2, "r_byte23");
    access(0, 1'b0, SZ_B, 32'h0000_0021, 32'h0, 32'h0000_00AA, 2, "r_byte21");
    access(0, 1'b0, SZ_H, 32'h0000_0022, 32'h0, 32'h0000_BBCC, 2, "r_half22");

    // Misaligned, out-of-range and illegal-size accesses
    access(0, 1'b1, SZ_W, 32'h0000_0030, 32'hCAFE_F00D, 32'h0, 2, "w_word30");
    access(0, 1'b1, SZ_H, 32'h0000_0031, 32'h0000_FFFF, 32'h0, 2, "w_half31_bad");
    chk("err_set", 32'(err0), 32'd1);
    chk("err_addr_first", ea0, 32'h0000_0031);
    access(0, 1'b0, SZ_W, 32'h0000_4000, 32'h0, 32'h0000_0000, 2, "r_oor");
    chk("err_addr_kept", ea0, 32'h0000_0031);
    access(0, 1'b0, SZ_X, 32'h0000_0030, 32'h0, 32'h0000_0000, 2, "r_size11");
    access(0, 1'b0, SZ_W, 32'h0000_0030, 32'h0, 32'hCAFE_F00D, 2, "r_word30_intact");
    chk("err_addr_final", ea0, 32'h0000_0031);

    // Reset during a read's WAIT state
    dad[0] = 32'h0000_0010; wr[0] = 1'b0; sz[0] = SZ_W; mreq[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstw_ackd_n", 32'(ack0), 32'd1);
    chk("rstw_ddt", ddt0, MARKER);
    chk("rstw_err", 32'(err0), 32'd0);
    chk("rstw_err_addr", ea0, 32'h0000_0000);
    mreq[0] = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Reset during a read's acknowledge cycle releases ACKD_n and DDT at once
    dad[0] = 32'h0000_0020; wr[0] = 1'b0; sz[0] = SZ_W; mreq[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 drv_en[0] = 1'b0;
    @(negedge clk);
    chk("rsta_ack_low", 32'(ack0), 32'd0);
    chk("rsta_rdata", ddt0, 32'hBBCC_AA44);
    #1 reset = 1'b1; drv_en[0] = 1'b1;
    #1;
    chk("rsta_ackd_n", 32'(ack0), 32'd1);
    chk("rsta_ddt", ddt0, MARKER);
    mreq[0] = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    access(0, 1'b0, SZ_W, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2, "r_after_reset");

    // Abort during WAIT, three wait states
    access(1, 1'b1, SZ_W, 32'h0000_0040, 32'h0BAD_F00D, 32'h0, 4, "w3_word40");
    dad[1] = 32'h0000_0040; wr[1] = 1'b1; sz[1] = SZ_W; mreq[1] = 1'b1;
    drv_val[1] = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1 mreq[1] = 1'b0; drv_val[1] = MARKER;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack1 == 1'b0) pulses++;
    end
    chk("abort_no_ack", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    access(1, 1'b0, SZ_W, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 4, "w3_r_after_abort");

    // Zero-wait back-to-back reads with MREQ held high
    access(2, 1'b1, SZ_W, 32'h0000_0050, 32'h0102_0304, 32'h0, 1, "w0_word50");
    access(2, 1'b1, SZ_W, 32'h0000_0054, 32'hA0B0_C0D0, 32'h0, 1, "w0_word54");
    dad[2] = 32'h0000_0050; wr[2] = 1'b0; sz[2] = SZ_W; mreq[2] = 1'b1;
    exp_q.push_back(32'h0102_0304);
    exp_q.push_back(32'hA0B0_C0D0);
    @(posedge clk); #1 drv_en[2] = 1'b0;
    @(negedge clk);
    chk("b2b_ack0", 32'(ack2), 32'd0);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk("b2b_rdata0", ddt2, want);
    @(posedge clk); #1 dad[2] = 32'h0000_0054; drv_en[2] = 1'b1;
    @(negedge clk);
    chk("b2b_ack1", 32'(ack2), 32'd1);
    chk("b2b_ddt_idle", ddt2, MARKER);
    @(posedge clk); #1 drv_en[2] = 1'b0;
    @(negedge clk);
    chk("b2b_ack2", 32'(ack2), 32'd0);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk("b2b_rdata1", ddt2, want);
    @(posedge clk); #1 mreq[2] = 1'b0; drv_en[2] = 1'b1;
    @(negedge clk);
    chk("b2b_ack3", 32'(ack2), 32'd1);

    // Responders that saw only legal accesses never flag an error
    chk("w3_err", 32'(err1), 32'd0);
    chk("w3_err_addr", ea1, 32'h0000_0000);
    chk("w0_err", 32'(err2), 32'd0);
    chk("w0_err_addr", ea2, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
